if2: RTL and testbench
======================

Name: if2

Overview:
- Instruction-fetch stage 2. Consumer end of the if1b valid/ready handshake.
- Accepts a virtual fetch address from if1b and issues a single-word read on the instruction-memory strobe/acknowledge bus.
- Returns the fetched word, with its address, to the next pipeline stage over a valid/ready handshake.
- Holds at most one fetch in flight. Back-pressures if1b while the fetch is busy or the result is unconsumed.

Parameters:
- RST_VADDR, 32'h00000000, value of if2_vaddr_out after reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  system reset, synchronous, active-high
- if2_ready_out  out  1  stage can accept an address this cycle
- if2_valid_in  in  1  if2_vaddr_in is valid (from if1b)
- if2_vaddr_in  in  32  fetch virtual address
- imem_stb  out  1  memory read request
- imem_addr  out  30  word address, equal to vaddr[31:2]
- imem_ack  in  1  memory read complete; imem_data valid
- imem_data  in  32  read data
- if2_ready_in  in  1  downstream can accept a result
- if2_valid_out  out  1  result valid
- if2_vaddr_out  out  32  address of the returned word
- if2_instr_out  out  32  fetched instruction word
- if2_fault_out  out  1  misaligned-address fault (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- States: IDLE, BUSY (request outstanding), HOLD (result presented).
- Reset values: state=IDLE, imem_stb=0, imem_addr=0, if2_valid_out=0, if2_vaddr_out=RST_VADDR, if2_instr_out=0, if2_fault_out=0. rst overrides all other inputs.
- if2_ready_out is combinational: (state==IDLE) | (state==HOLD & if2_ready_in). It never depends on if2_valid_in.
- Accept: if2_valid_in & if2_ready_out at a rising edge.
  - if2_vaddr_in is latched into if2_vaddr_out.
  - imem_addr is loaded with if2_vaddr_in[31:2].
  - Next state is BUSY with imem_stb=1.
- BUSY:
  - imem_stb and imem_addr are held stable until imem_ack is sampled high.
  - imem_ack may be high in the first cycle of stb.
  - On ack: imem_data goes to if2_instr_out, imem_stb drops to 0, if2_valid_out goes to 1, next state is HOLD.
- Minimum latency: accept at edge N, stb high during cycle N..N+1, ack sampled at edge N+1, if2_valid_out high after edge N+1.
  - That is 2 cycles from if2_valid_in to if2_valid_out with a zero-wait memory.
  - Each memory wait cycle adds 1.
- HOLD:
  - if2_valid_out, if2_vaddr_out, if2_instr_out and if2_fault_out are stable until if2_ready_in is sampled high.
  - On if2_ready_in without a new accept: valid_out goes to 0, next state is IDLE.
  - On if2_ready_in together with a new accept: valid_out goes to 0, next state is BUSY with the new address. This gives back-to-back operation with no idle cycle between results.
- imem_ack in IDLE or HOLD is ignored: no state change, no data capture.
- Reset mid-operation: the outstanding request is abandoned and stb is low after the reset edge. A late ack arriving after reset is ignored.
- Throughput: at most one result per 2 cycles, since BUSY lasts at least one cycle.
- if2_vaddr_in is not interpreted beyond [31:2] and [1:0]. No address translation is done here.

Optional Feature:
- Macro: IF2_ALIGN_CHECK_EN.
- Defined:
  - An accept with if2_vaddr_in[1:0]!=0 skips memory: no stb, straight to HOLD next cycle.
  - Outputs: if2_valid_out=1, if2_fault_out=1, if2_instr_out=0, if2_vaddr_out=full misaligned address. Latency is 1 cycle.
  - Aligned accepts clear if2_fault_out.
- Undefined:
  - vaddr[1:0] is ignored. Every accept goes through BUSY using vaddr[31:2].
  - if2_fault_out is constant 0.

Test Plan:
- Reset, then idle: after rst, outputs equal their reset values, if2_ready_out=1, imem_stb=0; an imem_ack pulse while idle leaves all outputs unchanged.
- Single fetch with zero-wait memory:
  - Stimulus: vaddr 32'h00004038 valid for 1 cycle; ack in the first stb cycle with data 32'hDEADBEEF.
  - Required: imem_addr=30'h0000100E; valid_out 2 cycles after the accept with instr DEADBEEF and vaddr 00004038.
- Wait states and back-pressure:
  - Stimulus: ack delayed 3 cycles; if2_ready_in held low 4 cycles after valid_out rises.
  - Required: stb and addr stable throughout the wait; outputs stable in HOLD; ready_out=0 in both phases; single transfer on ready_in.
- Streaming:
  - Stimulus: addresses 0x6030, 0x6034, 0x6038, 0x603C presented continuously; zero-wait memory; ready_in=1.
  - Required: 4 results in order, one every 2 cycles, with no address dropped or duplicated.
- Reset mid-operation: assert rst while BUSY, then ack one cycle later -> state is IDLE, valid_out=0, no result is emitted, and the next fetch of 0x603C behaves normally.
- Misaligned address 0x4039:
  - With IF2_ALIGN_CHECK_EN: no stb; fault=1, instr=0, vaddr=00004039 after 1 cycle.
  - Without the macro: fetch of word 30'h0000100E; fault=0.

Source files
------------

// File: rtl/if2.sv
// Instruction-fetch stage 2: takes a fetch address from if1b, performs one imem read,
// and hands {vaddr, instr} downstream. Optional IF2_ALIGN_CHECK_EN faults misaligned addresses.
module if2 #(
  parameter logic [31:0] RST_VADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if2_ready_out,
  input  logic        if2_valid_in,
  input  logic [31:0] if2_vaddr_in,
  output logic        imem_stb,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        if2_ready_in,
  output logic        if2_valid_out,
  output logic [31:0] if2_vaddr_out,
  output logic [31:0] if2_instr_out,
  output logic        if2_fault_out
);

  // state | meaning
  // IDLE  | nothing in flight, ready for an address
  // BUSY  | imem request outstanding, waiting for ack
  // HOLD  | result presented downstream, waiting for ready
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t state;
  logic   accept;

  assign if2_ready_out = (state == IDLE) | ((state == HOLD) & if2_ready_in);
  assign accept        = if2_valid_in & if2_ready_out;

`ifdef IF2_ALIGN_CHECK_EN
  logic fault_q;
  logic misaligned;
  assign misaligned    = |if2_vaddr_in[1:0];
  assign if2_fault_out = fault_q;
`else
  assign if2_fault_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      imem_stb      <= 1'b0;
      imem_addr     <= '0;
      if2_valid_out <= 1'b0;
      if2_vaddr_out <= RST_VADDR;
      if2_instr_out <= '0;
`ifdef IF2_ALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      case (state)
        BUSY: begin
          if (imem_ack) begin
            if2_instr_out <= imem_data;
            imem_stb      <= 1'b0;
            if2_valid_out <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (if2_ready_in) begin
            if2_valid_out <= 1'b0;
            state         <= IDLE;
          end
        end
        default: ;
      endcase

      // Accept only happens in IDLE/HOLD, so it cleanly overrides the HOLD release above.
      if (accept) begin
        if2_vaddr_out <= if2_vaddr_in;
`ifdef IF2_ALIGN_CHECK_EN
        if (misaligned) begin
          if2_valid_out <= 1'b1;
          if2_instr_out <= '0;
          fault_q       <= 1'b1;
          state         <= HOLD;
        end else begin
          imem_stb      <= 1'b1;
          imem_addr     <= if2_vaddr_in[31:2];
          fault_q       <= 1'b0;
          state         <= BUSY;
        end
`else
        imem_stb  <= 1'b1;
        imem_addr <= if2_vaddr_in[31:2];
        state     <= BUSY;
`endif
      end
    end
  end

endmodule

// File: tb/tb_if2.sv
// Self-checking bench for if2: scoreboard of expected results fed by the stimulus,
// a memory responder with configurable wait states, and a monitor comparing each result.
module tb_if2;
  localparam logic [31:0] RV = 32'h8000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid_in = 1'b0;
  logic [31:0] vaddr_in = '0;
  logic        ready_ctl = 1'b1, rnd_ready = 1'b1, rand_mode = 1'b0, ready_in;
  logic        mem_ack = 1'b0, force_ack = 1'b0, ack;
  logic [31:0] mem_data = '0, force_data = '0, data;
  logic        ready_out, stb, valid_out, fault_out;
  logic [29:0] addr;
  logic [31:0] vaddr_out, instr_out;

  assign ready_in = rand_mode ? rnd_ready : ready_ctl;
  assign ack      = mem_ack | force_ack;
  assign data     = force_ack ? force_data : mem_data;

  if2 #(.RST_VADDR(RV)) dut (
    .clk(clk), .rst(rst), .if2_ready_out(ready_out), .if2_valid_in(valid_in),
    .if2_vaddr_in(vaddr_in), .imem_stb(stb), .imem_addr(addr), .imem_ack(ack),
    .imem_data(data), .if2_ready_in(ready_in), .if2_valid_out(valid_out),
    .if2_vaddr_out(vaddr_out), .if2_instr_out(instr_out), .if2_fault_out(fault_out)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] ins;
    logic        flt;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0, fails = 0, cyc = 0, pops = 0, mem_wait = 0;
  bit          mem_en = 1'b1;
  logic [31:0] cur_va = '0;

  function automatic logic [31:0] memfn(input logic [29:0] w);
    if (w == 30'h0000100E) return 32'hDEADBEEF;
    return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Reference: what a single accepted address must eventually produce downstream.
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    e.va = a;
`ifdef IF2_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) begin
      e.ins = '0;
      e.flt = 1'b1;
      return e;
    end
`endif
    e.ins = memfn(a[31:2]);
    e.flt = 1'b0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rand_mode) begin
    #2 rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Memory responder: acks after mem_wait cycles of strobe, checks the address it is asked for.
  int cnt = 0;
  always @(negedge clk) begin
    if (mem_en && stb && !rst) begin
      chk("imem_addr", {2'b00, addr}, {2'b00, cur_va[31:2]});
      if (cnt >= mem_wait) begin
        mem_ack  = 1'b1;
        mem_data = memfn(addr);
      end else begin
        mem_ack = 1'b0;
      end
      cnt++;
    end else begin
      mem_ack = 1'b0;
      cnt     = 0;
    end
  end

  // Monitor: any presented result must match the scoreboard head; pop on transfer.
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got vaddr %h instr %h, expected none", vaddr_out, instr_out);
      end else begin
        chk("res_vaddr", vaddr_out, sb[0].va);
        chk("res_instr", instr_out, sb[0].ins);
        chk("res_fault", {31'b0, fault_out}, {31'b0, sb[0].flt});
        if (ready_in) begin
          void'(sb.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, output int acc);
    int n = 0;
    valid_in = 1'b1;
    vaddr_in = a;
    @(negedge clk);
    while (!ready_out && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!ready_out) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got ready_out 0, expected 1 within 200 cycles");
      acc = -1;
      valid_in = 1'b0;
      return;
    end
    acc    = cyc + 1;
    cur_va = a;
    sb.push_back(model(a));
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc, prev, n, p0;
    logic [31:0] a;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_stb", {31'b0, stb}, 32'd0);
    chk("rst_addr", {2'b00, addr}, 32'd0);
    chk("rst_vaddr", vaddr_out, RV);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_fault", {31'b0, fault_out}, 32'd0);
    chk("rst_ready", {31'b0, ready_out}, 32'd1);
    step;
    rst = 1'b0;

    // Stray ack while idle
    force_ack = 1'b1;
    force_data = 32'h1234_5678;
    step;
    force_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_valid", {31'b0, valid_out}, 32'd0);
    chk("idle_ack_instr", instr_out, 32'd0);
    chk("idle_ack_vaddr", vaddr_out, RV);
    chk("idle_ack_ready", {31'b0, ready_out}, 32'd1);

    // Single zero-wait fetch
    step;
    ready_ctl = 1'b1;
    mem_wait = 0;
    send(32'h0000_4038, acc);
    @(negedge clk);
    chk("single_stb", {31'b0, stb}, 32'd1);
    chk("single_addr", {2'b00, addr}, 32'h0000_100E);
    chk("single_busy_ready", {31'b0, ready_out}, 32'd0);
    chk("single_early_valid", {31'b0, valid_out}, 32'd0);
    @(negedge clk);
    chk("single_latency_valid", {31'b0, valid_out}, 32'd1);
    @(negedge clk);
    chk("single_done_valid", {31'b0, valid_out}, 32'd0);

    // Wait states and back-pressure
    step;
    mem_wait = 3;
    ready_ctl = 1'b0;
    send(32'h0000_5A50, acc);
    n = 0;
    @(negedge clk);
    while (!valid_out && n < 20) begin
      chk("wait_ready", {31'b0, ready_out}, 32'd0);
      chk("wait_stb", {31'b0, stb}, 32'd1);
      n++;
      @(negedge clk);
    end
    chk("wait_latency", n, 32'd4);
    repeat (4) begin
      @(negedge clk);
      chk("hold_ready", {31'b0, ready_out}, 32'd0);
      chk("hold_valid", {31'b0, valid_out}, 32'd1);
      chk("hold_stb", {31'b0, stb}, 32'd0);
    end
    p0 = pops;
    step;
    ready_ctl = 1'b1;
    @(negedge clk);
    chk("hold_release_ready", {31'b0, ready_out}, 32'd1);
    @(negedge clk);
    chk("hold_after_valid", {31'b0, valid_out}, 32'd0);
    chk("hold_single_xfer", pops - p0, 32'd1);

    // Streaming
    step;
    mem_wait = 0;
    p0 = pops;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(32'h0000_6030 + 32'(4 * i), acc);
      if (i > 0) chk("stream_gap", acc - prev, 32'd2);
      prev = acc;
    end
    drain;
    chk("stream_count", pops - p0, 32'd4);

    // Reset while BUSY, late ack afterwards
    step;
    mem_en = 1'b0;
    send(32'h0000_6030, acc);
    @(negedge clk);
    chk("midrst_busy_stb", {31'b0, stb}, 32'd1);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    sb.delete();
    force_ack = 1'b1;
    force_data = 32'hBAD0_BAD0;
    step;
    force_ack = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'b0, valid_out}, 32'd0);
    chk("midrst_stb", {31'b0, stb}, 32'd0);
    chk("midrst_ready", {31'b0, ready_out}, 32'd1);
    chk("midrst_vaddr", vaddr_out, RV);
    mem_en = 1'b1;
    step;
    p0 = pops;
    send(32'h0000_603C, acc);
    drain;
    chk("midrst_next_count", pops - p0, 32'd1);

    // Misaligned address
    step;
    ready_ctl = 1'b0;
    send(32'h0000_4039, acc);
    @(negedge clk);
`ifdef IF2_ALIGN_CHECK_EN
    chk("mis_stb", {31'b0, stb}, 32'd0);
    chk("mis_valid", {31'b0, valid_out}, 32'd1);
    chk("mis_fault", {31'b0, fault_out}, 32'd1);
`else
    chk("mis_stb", {31'b0, stb}, 32'd1);
    chk("mis_addr", {2'b00, addr}, 32'h0000_100E);
    chk("mis_fault", {31'b0, fault_out}, 32'd0);
`endif
    step;
    ready_ctl = 1'b1;
    drain;

    // Randomized traffic with random wait states and back-pressure
    rand_mode = 1'b1;
    p0 = pops;
    for (int i = 0; i < 40; i++) begin
      step;
      repeat ($urandom_range(0, 2)) step;
      mem_wait = $urandom_range(0, 3);
      a = $urandom;
      send(a, acc);
    end
    drain;
    chk("rand_count", pops - p0, 32'd40);
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
